diffeq_job_driver: RTL and testbench

Host-side driver for the diffeq solver core. It accepts a job descriptor (X, Y, U, A, DX) over a valid/ready handshake and owns the solver's reset. It holds all solver input ports stable for the whole job and tracks the solver's loop in lockstep with a shadow x register. It captures Xout/Yout/Uout at completion and returns them with an iteration count over a second valid/ready handshake, aborting runaway jobs with a timeout.

---
 rtl/diffeq_pkg.sv | 17 +
 rtl/diffeq_job_driver_x_tracker.sv | 46 ++++
 rtl/diffeq_job_driver.sv | 236 +++++++++++++++++++++++
 tb/tb_diffeq_job_driver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/diffeq_pkg.sv
// Shared definitions for the diffeq solver job driver: default widths and
// the driver's state encoding.
package diffeq_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ITER_W_DEF   = 16;
    localparam int MAX_ITER_DEF = 1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_CAPT   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

endpackage : diffeq_pkg

// File: rtl/diffeq_job_driver_x_tracker.sv
// Shadow copy of the solver's x loop variable. It steps in lockstep with the
// solver so the driver knows which cycle the solver leaves its loop, and it
// counts the iterations executed.
import diffeq_pkg::*;

module diffeq_x_tracker #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ITER_W = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] x_init,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] dx,
    output logic              loop_continue,
    output logic [ITER_W-1:0] cnt
);

    logic [DATA_W-1:0] x_sh_r;
    logic [ITER_W-1:0] cnt_r;

    // Shadow x and iteration counter: reload at job start, advance per iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_sh_r <= '0;
            cnt_r  <= '0;
        end else if (load) begin
            x_sh_r <= x_init;
            cnt_r  <= '0;
        end else if (step) begin
            // Wraps modulo 2^DATA_W exactly like the solver's own adder.
            x_sh_r <= x_sh_r + dx;
            cnt_r  <= cnt_r + ITER_W'(1);
        end else begin
            x_sh_r <= x_sh_r;
            cnt_r  <= cnt_r;
        end
    end

    // Same unsigned loop test the solver evaluates this cycle.
    assign loop_continue = (x_sh_r < a);
    assign cnt           = cnt_r;

endmodule : diffeq_x_tracker

// File: rtl/diffeq_job_driver.sv
// Host-side driver for the diffeq solver core. Accepts a job descriptor,
// owns the solver reset, holds the solver inputs stable for the job, tracks
// the solver loop with a shadow x register and returns the captured results
// with an iteration count (or a timeout flag for runaway jobs).
import diffeq_pkg::*;

module diffeq_job_driver #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ITER_W   = ITER_W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [DATA_W-1:0] job_x,
    input  logic [DATA_W-1:0] job_y,
    input  logic [DATA_W-1:0] job_u,
    input  logic [DATA_W-1:0] job_a,
    input  logic [DATA_W-1:0] job_dx,
    output logic              sol_reset,
    output logic [DATA_W-1:0] sol_x,
    output logic [DATA_W-1:0] sol_y,
    output logic [DATA_W-1:0] sol_u,
    output logic [DATA_W-1:0] sol_a,
    output logic [DATA_W-1:0] sol_dx,
    input  logic [DATA_W-1:0] sol_xout,
    input  logic [DATA_W-1:0] sol_yout,
    input  logic [DATA_W-1:0] sol_uout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_x,
    output logic [DATA_W-1:0] res_y,
    output logic [DATA_W-1:0] res_u,
    output logic [ITER_W-1:0] res_iters,
    output logic              res_timeout
);

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

    state_t            state_r;
    state_t            state_next_s;
    logic              job_ready_s;
    logic              load_s;
    logic              step_s;
    logic              abort_s;
    logic              done_s;
    logic              loop_continue_s;
    logic              at_limit_s;
    logic [ITER_W-1:0] cnt_s;

    logic              sol_reset_r;
    logic [DATA_W-1:0] sol_x_r;
    logic [DATA_W-1:0] sol_y_r;
    logic [DATA_W-1:0] sol_u_r;
    logic [DATA_W-1:0] sol_a_r;
    logic [DATA_W-1:0] sol_dx_r;
    logic              res_valid_r;
    logic [DATA_W-1:0] res_x_r;
    logic [DATA_W-1:0] res_y_r;
    logic [DATA_W-1:0] res_u_r;
    logic [ITER_W-1:0] res_iters_r;
    logic              res_timeout_r;

    diffeq_x_tracker #(
        .DATA_W (DATA_W),
        .ITER_W (ITER_W)
    ) u_x_tracker (
        .clk           (clk),
        .reset         (reset),
        .load          (load_s),
        .step          (step_s),
        .x_init        (sol_x_r),
        .a             (sol_a_r),
        .dx            (sol_dx_r),
        .loop_continue (loop_continue_s),
        .cnt           (cnt_s)
    );

    assign at_limit_s = (cnt_s == MAX_ITER_C);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic for the job lifecycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (job_valid) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                if (!loop_continue_s) begin
                    state_next_s = ST_CAPT;
                end else if (at_limit_s) begin
                    state_next_s = ST_RESULT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_CAPT: begin
                state_next_s = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESULT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Per-state control strobes derived from the current state.
    always_comb begin
        job_ready_s = 1'b0;
        load_s      = 1'b0;
        step_s      = 1'b0;
        abort_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                job_ready_s = 1'b1;
            end
            ST_LOAD: begin
                load_s = 1'b1;
            end
            ST_RUN: begin
                if (loop_continue_s) begin
                    step_s  = !at_limit_s;
                    abort_s = at_limit_s;
                end else begin
                    done_s = 1'b1;
                end
            end
            ST_CAPT: begin
                job_ready_s = 1'b0;
            end
            ST_RESULT: begin
                job_ready_s = 1'b0;
            end
            default: begin
                job_ready_s = 1'b0;
            end
        endcase
    end

    // Solver-facing registers: inputs latched only at accept, reset released
    // for the job and re-asserted as soon as the solver has finished or aborted.
    always_ff @(posedge clk) begin
        if (reset) begin
            sol_reset_r <= 1'b1;
            sol_x_r     <= '0;
            sol_y_r     <= '0;
            sol_u_r     <= '0;
            sol_a_r     <= '0;
            sol_dx_r    <= '0;
        end else if (job_ready_s && job_valid) begin
            sol_reset_r <= 1'b0;
            sol_x_r     <= job_x;
            sol_y_r     <= job_y;
            sol_u_r     <= job_u;
            sol_a_r     <= job_a;
            sol_dx_r    <= job_dx;
        end else if (abort_s || done_s) begin
            sol_reset_r <= 1'b1;
        end else begin
            sol_reset_r <= sol_reset_r;
        end
    end

    // Result registers: zeroed on abort, captured from the solver in CAPT,
    // otherwise held so they stay stable while offered downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_r   <= 1'b0;
            res_x_r       <= '0;
            res_y_r       <= '0;
            res_u_r       <= '0;
            res_iters_r   <= '0;
            res_timeout_r <= 1'b0;
        end else begin
            res_valid_r <= (state_next_s == ST_RESULT);
            if (abort_s) begin
                res_x_r       <= '0;
                res_y_r       <= '0;
                res_u_r       <= '0;
                res_iters_r   <= cnt_s;
                res_timeout_r <= 1'b1;
            end else if (state_r == ST_CAPT) begin
                res_x_r       <= sol_xout;
                res_y_r       <= sol_yout;
                res_u_r       <= sol_uout;
                res_iters_r   <= cnt_s;
                res_timeout_r <= 1'b0;
            end else begin
                res_x_r       <= res_x_r;
                res_y_r       <= res_y_r;
                res_u_r       <= res_u_r;
                res_iters_r   <= res_iters_r;
                res_timeout_r <= res_timeout_r;
            end
        end
    end

    assign job_ready   = job_ready_s;
    assign sol_reset   = sol_reset_r;
    assign sol_x       = sol_x_r;
    assign sol_y       = sol_y_r;
    assign sol_u       = sol_u_r;
    assign sol_a       = sol_a_r;
    assign sol_dx      = sol_dx_r;
    assign res_valid   = res_valid_r;
    assign res_x       = res_x_r;
    assign res_y       = res_y_r;
    assign res_u       = res_u_r;
    assign res_iters   = res_iters_r;
    assign res_timeout = res_timeout_r;

endmodule : diffeq_job_driver

// File: tb/tb_diffeq_job_driver.sv
// Bench for diffeq_job_driver paired with a behavioural diffeq solver core.
// Expected results come from a plain-arithmetic loop over the diffeq update
// equations; latencies from the documented N+3 / MAX_ITER+2 rules.
module tb_diffeq_job_driver;

    localparam int DW     = 32;
    localparam int IW     = 16;
    localparam int TB_MAX = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          job_valid;
    logic          job_ready;
    logic [DW-1:0] job_x, job_y, job_u, job_a, job_dx;
    logic          sol_reset;
    logic [DW-1:0] sol_x, sol_y, sol_u, sol_a, sol_dx;
    logic [DW-1:0] sol_xout, sol_yout, sol_uout;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_x, res_y, res_u;
    logic [IW-1:0] res_iters;
    logic          res_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    diffeq_job_driver #(.DATA_W(DW), .ITER_W(IW), .MAX_ITER(TB_MAX)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_x(job_x), .job_y(job_y), .job_u(job_u), .job_a(job_a), .job_dx(job_dx),
        .sol_reset(sol_reset),
        .sol_x(sol_x), .sol_y(sol_y), .sol_u(sol_u), .sol_a(sol_a), .sol_dx(sol_dx),
        .sol_xout(sol_xout), .sol_yout(sol_yout), .sol_uout(sol_uout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_x(res_x), .res_y(res_y), .res_u(res_u),
        .res_iters(res_iters), .res_timeout(res_timeout)
    );

    // Behavioural diffeq solver core: loads on the first un-reset cycle, then
    // iterates while x < a and writes its outputs when the loop test fails.
    // Reset only clears the looping flag; outputs keep their last value.
    logic [DW-1:0] m_x, m_y, m_u;
    logic          m_looping;
    initial begin
        m_looping = 1'b0;
        m_x = '0; m_y = '0; m_u = '0;
        sol_xout = '0; sol_yout = '0; sol_uout = '0;
    end
    always @(posedge clk) begin
        if (sol_reset) begin
            m_looping <= 1'b0;
        end else if (!m_looping) begin
            m_x <= sol_x; m_y <= sol_y; m_u <= sol_u;
            m_looping <= 1'b1;
        end else if (m_x < sol_a) begin
            m_x <= m_x + sol_dx;
            m_u <= m_u - 32'd3 * m_x * m_u * sol_dx - 32'd3 * m_y * sol_dx;
            m_y <= m_y + m_u * sol_dx;
        end else begin
            sol_xout <= m_x; sol_yout <= m_y; sol_uout <= m_u;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: run the diffeq loop to completion (or to the iteration cap).
    task automatic ref_job(input logic [DW-1:0] x0, y0, u0, a, dx,
                           output logic [DW-1:0] rx, ry, ru,
                           output int iters, output logic to);
        logic [DW-1:0] x, y, u, x1, y1, u1;
        x = x0; y = y0; u = u0; iters = 0; to = 1'b0;
        while (x < a) begin
            if (iters == TB_MAX) begin
                to = 1'b1;
                break;
            end
            x1 = x + dx;
            u1 = u - 32'd3 * x * u * dx - 32'd3 * y * dx;
            y1 = y + u * dx;
            x = x1; y = y1; u = u1;
            iters++;
        end
        if (to) begin
            rx = '0; ry = '0; ru = '0;
        end else begin
            rx = x; ry = y; ru = u;
        end
    endtask

    // Offer one job, wait for its result, check it, optionally stall the
    // result handshake for hold cycles, then complete the handshake.
    task automatic run_job(input string nm, input logic [DW-1:0] x, y, u, a, dx, input int hold);
        logic [DW-1:0] ex, ey, eu;
        int            eit;
        logic          eto;
        int            lat;
        int            exp_lat;
        logic          stable;
        ref_job(x, y, u, a, dx, ex, ey, eu, eit, eto);
        exp_lat = eto ? TB_MAX + 2 : eit + 3;
        chk({nm, "_job_ready"}, 64'(job_ready), 64'd1);
        job_valid = 1'b1;
        job_x = x; job_y = y; job_u = u; job_a = a; job_dx = dx;
        @(posedge clk); #1;
        job_valid = 1'b0;
        job_x = ~x; job_a = ~a; job_dx = ~dx;
        lat = 0;
        stable = 1'b1;
        while (!res_valid && lat < 200) begin
            if (sol_a !== a || sol_dx !== dx || sol_x !== x) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_sol_stable"}, 64'(stable), 64'd1);
        chk({nm, "_res_x"}, 64'(res_x), 64'(ex));
        chk({nm, "_res_y"}, 64'(res_y), 64'(ey));
        chk({nm, "_res_u"}, 64'(res_u), 64'(eu));
        chk({nm, "_res_iters"}, 64'(res_iters), 64'(eit));
        chk({nm, "_res_timeout"}, 64'(res_timeout), 64'(eto));
        chk({nm, "_sol_reset"}, 64'(sol_reset), 64'd1);
        if (hold > 0) begin
            job_valid = 1'b1;
            job_x = 32'hDEAD; job_a = 32'hBEEF; job_dx = 32'd7;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (res_valid !== 1'b1 || job_ready !== 1'b0 || res_x !== ex ||
                    res_iters !== IW'(eit) || sol_x !== x) stable = 1'b0;
            end
            job_valid = 1'b0;
            chk({nm, "_hold_stable"}, 64'(stable), 64'd1);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({nm, "_res_valid_drop"}, 64'(res_valid), 64'd0);
        chk({nm, "_back_ready"}, 64'(job_ready), 64'd1);
    endtask

    initial begin
        logic [DW-1:0] rx, ry, ru, rr;
        reset = 1'b1;
        job_valid = 1'b0; res_ready = 1'b0;
        job_x = '0; job_y = '0; job_u = '0; job_a = '0; job_dx = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_job_ready", 64'(job_ready), 64'd1);
        chk("rst_sol_reset", 64'(sol_reset), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_x", 64'(res_x), 64'd0);
        chk("rst_res_iters", 64'(res_iters), 64'd0);
        chk("rst_res_timeout", 64'(res_timeout), 64'd0);
        chk("rst_sol_a", 64'(sol_a), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_job("one_iter", 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 0);
        chk("one_iter_u_literal", 64'(res_u), 64'hFFFF_FFFE);
        run_job("dx2", 32'd0, 32'd0, 32'd0, 32'd10, 32'd2, 0);
        chk("dx2_x_literal", 64'(res_x), 64'd10);
        run_job("zero_iter", 32'd20, 32'd7, 32'd9, 32'd10, 32'd5, 0);
        run_job("timeout", 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 0);
        run_job("after_to", 32'd3, 32'd2, 32'd4, 32'd6, 32'd1, 0);
        run_job("hold", 32'd1, 32'd5, 32'd6, 32'd4, 32'd1, 5);
        run_job("b2b", 32'd0, 32'd9, 32'd3, 32'd3, 32'd3, 0);

        // Reset in the middle of a running job.
        job_valid = 1'b1;
        job_x = 32'd0; job_y = 32'd0; job_u = 32'd0; job_a = 32'd10; job_dx = 32'd2;
        @(posedge clk); #1;
        job_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_sol_reset", 64'(sol_reset), 64'd1);
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_job_ready", 64'(job_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_result", 64'(res_valid), 64'd0);
        run_job("after_rst", 32'd0, 32'd0, 32'd0, 32'd10, 32'd2, 0);

        // Randomised jobs, including wraparound and timeout cases.
        for (int k = 0; k < 10; k++) begin
            rx = 32'($urandom_range(0, 20));
            rr = 32'($urandom_range(0, 30));
            ry = $urandom;
            ru = $urandom;
            if (k == 9) rx = 32'hFFFF_FFF0;
            run_job($sformatf("rnd%0d", k), rx, ry, ru, rr,
                    (k == 9) ? 32'h0000_0020 : 32'($urandom_range(0, 4)),
                    (k % 3 == 0) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_diffeq_job_driver
